// File: rtl/line_win_checker_if.sv
// Request/result and board-read signals of line_win_checker.
// win_axis exists only when LINE_WIN_AXIS_REPORT_EN is defined.
interface line_win_checker_if #(
  parameter int unsigned RW = 3,
  parameter int unsigned CW = 3,
  parameter int unsigned PW = 2
);
  logic          start;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] player;
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [PW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [PW-1:0] winner;
`ifdef LINE_WIN_AXIS_REPORT_EN
  logic [1:0]    win_axis;
`endif

  modport master (
    output start, row, col, player, rd_data,
`ifdef LINE_WIN_AXIS_REPORT_EN
    input  win_axis,
`endif
    input  rd_en, rd_row, rd_col, busy, done, winner
  );

  modport slave (
    input  start, row, col, player, rd_data,
`ifdef LINE_WIN_AXIS_REPORT_EN
    output win_axis,
`endif
    output rd_en, rd_row, rd_col, busy, done, winner
  );
endinterface

// File: rtl/line_win_checker.sv
// Connect-four win detector: walks both rays of the four axes through the placed piece.
// Optional win_axis reporting is enabled by defining LINE_WIN_AXIS_REPORT_EN.
module line_win_checker #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned RW      = 3,
  parameter int unsigned CW      = 3,
  parameter int unsigned WIN_LEN = 4,
  parameter int unsigned PW      = 2
) (
  input logic               clk,
  input logic               rst_n,
  line_win_checker_if.slave bus
);
  localparam int unsigned DW = $clog2(WIN_LEN + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StProbe = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [RW:0]   RowLim  = (RW + 1)'(ROWS);
  localparam logic [CW:0]   ColLim  = (CW + 1)'(COLS);
  localparam logic [DW-1:0] DistEnd = DW'(WIN_LEN);
  localparam logic [DW-1:0] CntLast = DW'(WIN_LEN - 2);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] player_q, player_d;
  logic [1:0]    axis_q, axis_d;
  logic          neg_q, neg_d;
  logic [DW-1:0] dist_q, dist_d;
  logic [DW-1:0] count_q, count_d;
  logic [PW-1:0] winner_q, winner_d;
`ifdef LINE_WIN_AXIS_REPORT_EN
  logic [1:0]    win_axis_q, win_axis_d;
`endif

  logic [RW:0] dist_r, probe_r;
  logic [CW:0] dist_c, probe_c;
  logic        col_neg, oob, ray_stop, hit, start_bad, end_ray;

  always_comb begin
    dist_r  = (RW + 1)'(dist_q);
    dist_c  = (CW + 1)'(dist_q);
    col_neg = neg_q ^ (axis_q == 2'd3);
    probe_r = {1'b0, row_q};
    probe_c = {1'b0, col_q};
    if (axis_q != 2'd1) probe_r = neg_q ? probe_r - dist_r : probe_r + dist_r;
    if (axis_q != 2'd0) probe_c = col_neg ? probe_c - dist_c : probe_c + dist_c;
    // Sign bit set means the probe went below 0 or past 2^RW; either way off the board.
    oob = probe_r[RW] | ({1'b0, probe_r[RW-1:0]} >= RowLim) |
          probe_c[CW] | ({1'b0, probe_c[CW-1:0]} >= ColLim);
    ray_stop = (dist_q == DistEnd) | oob;
  end

  assign hit       = (bus.rd_data == player_q);
  assign start_bad = (bus.player == '0) | ({1'b0, bus.row} >= RowLim) |
                     ({1'b0, bus.col} >= ColLim);

  assign bus.rd_en  = (state_q == StProbe) & ~ray_stop;
  assign bus.rd_row = bus.rd_en ? probe_r[RW-1:0] : '0;
  assign bus.rd_col = bus.rd_en ? probe_c[CW-1:0] : '0;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.winner = winner_q;
`ifdef LINE_WIN_AXIS_REPORT_EN
  assign bus.win_axis = win_axis_q;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    player_d = player_q;
    axis_d   = axis_q;
    neg_d    = neg_q;
    dist_d   = dist_q;
    count_d  = count_q;
    winner_d = winner_q;
`ifdef LINE_WIN_AXIS_REPORT_EN
    win_axis_d = win_axis_q;
`endif
    end_ray = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          row_d    = bus.row;
          col_d    = bus.col;
          player_d = bus.player;
          winner_d = '0;
`ifdef LINE_WIN_AXIS_REPORT_EN
          win_axis_d = 2'd0;
`endif
          axis_d   = 2'd0;
          neg_d    = 1'b0;
          dist_d   = DW'(1);
          count_d  = '0;
          state_d  = start_bad ? StDone : StProbe;
        end
      end
      StProbe: begin
        if (ray_stop) end_ray = 1'b1;
        else          state_d = StCheck;
      end
      StCheck: begin
        if (hit) begin
          count_d = count_q + 1'b1;
          dist_d  = dist_q + 1'b1;
          if (count_q == CntLast) begin
            winner_d = player_q;
`ifdef LINE_WIN_AXIS_REPORT_EN
            win_axis_d = axis_q;
`endif
            state_d  = StDone;
          end else begin
            state_d = StProbe;
          end
        end else begin
          end_ray = 1'b1;
        end
      end
      StDone: state_d = StIdle;
    endcase

    // The negative ray continues the positive ray's count along the same axis.
    if (end_ray) begin
      if (!neg_q) begin
        neg_d   = 1'b1;
        dist_d  = DW'(1);
        state_d = StProbe;
      end else if (axis_q == 2'd3) begin
        state_d = StDone;
      end else begin
        axis_d  = axis_q + 2'd1;
        neg_d   = 1'b0;
        dist_d  = DW'(1);
        count_d = '0;
        state_d = StProbe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      player_q <= '0;
      axis_q   <= 2'd0;
      neg_q    <= 1'b0;
      dist_q   <= '0;
      count_q  <= '0;
      winner_q <= '0;
`ifdef LINE_WIN_AXIS_REPORT_EN
      win_axis_q <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      player_q <= player_d;
      axis_q   <= axis_d;
      neg_q    <= neg_d;
      dist_q   <= dist_d;
      count_q  <= count_d;
      winner_q <= winner_d;
`ifdef LINE_WIN_AXIS_REPORT_EN
      win_axis_q <= win_axis_d;
`endif
    end
  end
endmodule

// File: tb/tb_line_win_checker.sv
// Self-checking bench for line_win_checker: directed scenarios plus random boards
// compared against a ray-walking reference model.
module tb_line_win_checker;
  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int RW      = 3;
  localparam int CW      = 3;
  localparam int WIN_LEN = 4;
  localparam int PW      = 2;
  localparam int MaxLat  = 16 * WIN_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  line_win_checker_if #(.RW(RW), .CW(CW), .PW(PW)) bus ();

  line_win_checker #(
    .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW), .WIN_LEN(WIN_LEN), .PW(PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] board [ROWS][COLS];
  int got_r[$], got_c[$], exp_r[$], exp_c[$];
  int m_win, m_axis, m_lat;

  // Board memory: one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      if (int'(bus.rd_row) < ROWS && int'(bus.rd_col) < COLS)
        bus.rd_data <= board[int'(bus.rd_row)][int'(bus.rd_col)];
      else
        bus.rd_data <= '0;
    end
  end

  // Read logger and address-legality monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.rd_en === 1'b1) begin
        got_r.push_back(int'(bus.rd_row));
        got_c.push_back(int'(bus.rd_col));
        if (int'(bus.rd_row) >= ROWS || int'(bus.rd_col) >= COLS) begin
          errors++;
          $display("FAIL rd_addr_in_board: got (%0d,%0d), required row<%0d col<%0d",
                   bus.rd_row, bus.rd_col, ROWS, COLS);
        end
      end else if (bus.rd_row !== '0 || bus.rd_col !== '0) begin
        errors++;
        $display("FAIL rd_addr_idle_zero: got (%0d,%0d), required (0,0)",
                 bus.rd_row, bus.rd_col);
      end
    end
  end

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board[r][c] = '0;
  endtask

  // Reference: walk each ray cell by cell; cost 2 per read, 1 per read-less ray end.
  task automatic model(input int r, input int c, input int p);
    exp_r.delete();
    exp_c.delete();
    m_win = 0;
    m_axis = 0;
    m_lat = 1;
    if (p == 0 || r >= ROWS || c >= COLS) return;
    for (int a = 0; a < 4; a++) begin
      int dr, dc, cnt;
      dr = (a == 1) ? 0 : 1;
      dc = (a == 0) ? 0 : ((a == 3) ? -1 : 1);
      cnt = 0;
      for (int s = 1; s >= -1; s -= 2) begin
        int d;
        bit stop;
        d = 1;
        stop = 0;
        while (!stop) begin
          int pr, pc;
          pr = r + s * d * dr;
          pc = c + s * d * dc;
          if (d == WIN_LEN || pr < 0 || pr >= ROWS || pc < 0 || pc >= COLS) begin
            m_lat += 1;
            stop = 1;
          end else begin
            exp_r.push_back(pr);
            exp_c.push_back(pc);
            m_lat += 2;
            if (int'(board[pr][pc]) == p) begin
              cnt++;
              d++;
              if (cnt == WIN_LEN - 1) begin
                m_win = p;
                m_axis = a;
                return;
              end
            end else begin
              stop = 1;
            end
          end
        end
      end
    end
  endtask

  function automatic bit reads_equal(input int er[$], input int ec[$]);
    if (got_r.size() != er.size() || got_c.size() != ec.size()) return 0;
    foreach (er[i]) if (got_r[i] != er[i] || got_c[i] != ec[i]) return 0;
    return 1;
  endfunction

  task automatic run_check(input int r, input int c, input int p,
                           output int w, output int ax, output int lat, output bit to);
    @(negedge clk);
    bus.row = RW'(r);
    bus.col = CW'(c);
    bus.player = PW'(p);
    bus.start = 1'b1;
    got_r.delete();
    got_c.delete();
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < MaxLat + 4) begin
      @(negedge clk);
      lat++;
    end
    to = (bus.done !== 1'b1);
    w = int'(bus.winner);
`ifdef LINE_WIN_AXIS_REPORT_EN
    ax = int'(bus.win_axis);
`else
    ax = 0;
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rd_en} !== 3'b000 || bus.winner !== '0) begin
      errors++;
      $display("FAIL reset_held: got busy/done/rd_en=%b%b%b winner=%0d, required 0",
               bus.busy, bus.done, bus.rd_en, bus.winner);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rd_en} !== 3'b000 || bus.rd_row !== '0 ||
        bus.rd_col !== '0 || bus.winner !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy/done/rd_en=%b%b%b row=%0d col=%0d winner=%0d",
               bus.busy, bus.done, bus.rd_en, bus.rd_row, bus.rd_col, bus.winner);
    end
`ifdef LINE_WIN_AXIS_REPORT_EN
    checks++;
    if (bus.win_axis !== 2'd0) begin
      errors++;
      $display("FAIL reset_win_axis: got %0d, required 0", bus.win_axis);
    end
`endif
  endtask

  task automatic test_vertical();
    int w, ax, lat;
    bit to;
    int er[$] = '{4, 2, 1, 0};
    int ec[$] = '{2, 2, 2, 2};
    clear_board();
    board[0][2] = 2'd1; board[1][2] = 2'd1; board[2][2] = 2'd1;
    run_check(3, 2, 1, w, ax, lat, to);
    checks++;
    if (to || lat != 9) begin
      errors++; $display("FAIL vert_latency: got %0d (timeout=%0d), required 9", lat, to);
    end
    checks++;
    if (w != 1) begin errors++; $display("FAIL vert_winner: got %0d, required 1", w); end
    checks++;
    if (!reads_equal(er, ec)) begin
      errors++; $display("FAIL vert_reads: got %0d reads, required 4 matching", got_r.size());
    end
`ifdef LINE_WIN_AXIS_REPORT_EN
    checks++;
    if (ax != 0) begin errors++; $display("FAIL vert_axis: got %0d, required 0", ax); end
`endif
  endtask

  task automatic test_horizontal();
    int w, ax, lat;
    bit to;
    int er[$] = '{1, 0, 0, 0, 0};
    int ec[$] = '{3, 4, 2, 1, 0};
    clear_board();
    board[0][0] = 2'd2; board[0][1] = 2'd2; board[0][2] = 2'd2;
    run_check(0, 3, 2, w, ax, lat, to);
    checks++;
    if (to || lat != 12) begin
      errors++; $display("FAIL horiz_latency: got %0d (timeout=%0d), required 12", lat, to);
    end
    checks++;
    if (w != 2) begin errors++; $display("FAIL horiz_winner: got %0d, required 2", w); end
    checks++;
    if (!reads_equal(er, ec)) begin
      errors++; $display("FAIL horiz_reads: got %0d reads, required 5 matching", got_r.size());
    end
`ifdef LINE_WIN_AXIS_REPORT_EN
    checks++;
    if (ax != 1) begin errors++; $display("FAIL horiz_axis: got %0d, required 1", ax); end
`endif
  endtask

  task automatic test_corner();
    int w, ax, lat;
    bit to;
    int er[$] = '{4, 5, 4};
    int ec[$] = '{6, 5, 5};
    clear_board();
    run_check(5, 6, 1, w, ax, lat, to);
    checks++;
    if (to || lat != 12) begin
      errors++; $display("FAIL corner_latency: got %0d (timeout=%0d), required 12", lat, to);
    end
    checks++;
    if (w != 0) begin errors++; $display("FAIL corner_winner: got %0d, required 0", w); end
    checks++;
    if (!reads_equal(er, ec)) begin
      errors++; $display("FAIL corner_reads: got %0d reads, required 3 matching", got_r.size());
    end
  endtask

  task automatic test_broken();
    int w, ax, lat;
    bit to;
    clear_board();
    board[0][0] = 2'd1; board[0][1] = 2'd1; board[0][4] = 2'd1;
    model(0, 2, 1);
    run_check(0, 2, 1, w, ax, lat, to);
    checks++;
    if (to || w != 0 || lat != m_lat) begin
      errors++;
      $display("FAIL broken_gap: got winner %0d lat %0d, required winner 0 lat %0d",
               w, lat, m_lat);
    end
    board[0][3] = 2'd2;
    model(0, 2, 1);
    run_check(0, 2, 1, w, ax, lat, to);
    checks++;
    if (to || w != 0 || lat != m_lat) begin
      errors++;
      $display("FAIL broken_opponent: got winner %0d lat %0d, required winner 0 lat %0d",
               w, lat, m_lat);
    end
  endtask

  task automatic test_invalid();
    int w, ax, lat;
    bit to;
    int ps[3] = '{0, 1, 2};
    int rs[3] = '{2, 6, 0};
    int cs[3] = '{2, 0, 7};
    for (int i = 0; i < 3; i++) begin
      run_check(rs[i], cs[i], ps[i], w, ax, lat, to);
      checks++;
      if (to || lat != 1 || w != 0 || got_r.size() != 0) begin
        errors++;
        $display("FAIL invalid_start_%0d: got lat %0d winner %0d reads %0d, required 1/0/0",
                 i, lat, w, got_r.size());
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int er[$] = '{4, 2, 1, 0};
    int ec[$] = '{2, 2, 2, 2};
    clear_board();
    board[0][2] = 2'd1; board[1][2] = 2'd1; board[2][2] = 2'd1;
    @(negedge clk);
    bus.row = 3'd3; bus.col = 3'd2; bus.player = 2'd1; bus.start = 1'b1;
    got_r.delete(); got_c.delete();
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b, required 1", bus.busy);
    end
    repeat (2) begin @(negedge clk); lat++; end
    bus.row = 3'd0; bus.col = 3'd0; bus.player = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < MaxLat + 4) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 9 || bus.winner !== 2'd1 || !reads_equal(er, ec)) begin
      errors++;
      $display("FAIL start_while_busy: got lat %0d winner %0d reads %0d, required 9/1/4",
               lat, bus.winner, got_r.size());
    end
    // start held during the done cycle must not launch a scan
    bus.row = 3'd5; bus.col = 3'd6; bus.player = 2'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy %b done %b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int w, ax, lat;
    bit to;
    clear_board();
    board[0][2] = 2'd1; board[1][2] = 2'd1; board[2][2] = 2'd1;
    run_check(3, 2, 1, w, ax, lat, to);
    @(negedge clk);
    bus.row = 3'd5; bus.col = 3'd6; bus.player = 2'd1; bus.start = 1'b1;
    got_r.delete(); got_c.delete();
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    checks++;
    if (bus.busy !== 1'b1 || bus.winner !== 2'd0) begin
      errors++;
      $display("FAIL b2b_accept_clear: got busy %b winner %0d, required 1 0",
               bus.busy, bus.winner);
    end
    while (bus.done !== 1'b1 && lat < MaxLat + 4) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 12 || bus.winner !== 2'd0) begin
      errors++;
      $display("FAIL b2b_second: got lat %0d winner %0d, required 12 0", lat, bus.winner);
    end
  endtask

  task automatic test_reset_midscan();
    int seen;
    clear_board();
    board[0][2] = 2'd1; board[1][2] = 2'd1; board[2][2] = 2'd1;
    @(negedge clk);
    bus.row = 3'd3; bus.col = 3'd2; bus.player = 2'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rd_en !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midscan_active: got rd_en %b busy %b, required 1 1", bus.rd_en, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rd_en} !== 3'b000 || bus.winner !== '0 ||
        bus.rd_row !== '0 || bus.rd_col !== '0) begin
      errors++;
      $display("FAIL midscan_reset: got busy/done/rd_en=%b%b%b row %0d col %0d winner %0d",
               bus.busy, bus.done, bus.rd_en, bus.rd_row, bus.rd_col, bus.winner);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (bus.done === 1'b1) seen++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (bus.done === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midscan_no_done: got %0d done cycles, required 0", seen);
    end
  endtask

  task automatic test_random();
    int w, ax, lat, r, c, p, v;
    bit to;
    for (int it = 0; it < 80; it++) begin
      for (int rr = 0; rr < ROWS; rr++)
        for (int cc = 0; cc < COLS; cc++) begin
          v = int'($urandom_range(0, 9));
          board[rr][cc] = (v < 5) ? 2'd1 : ((v < 8) ? 2'd2 : 2'd0);
        end
      r = int'($urandom_range(0, ROWS));
      c = int'($urandom_range(0, COLS));
      p = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 2));
      model(r, c, p);
      run_check(r, c, p, w, ax, lat, to);
      checks++;
      if (to || w != m_win || lat != m_lat) begin
        errors++;
        $display("FAIL rand_%0d result (%0d,%0d,p%0d): got winner %0d lat %0d, required %0d %0d",
                 it, r, c, p, w, lat, m_win, m_lat);
      end
      checks++;
      if (!reads_equal(exp_r, exp_c)) begin
        errors++;
        $display("FAIL rand_%0d reads: got %0d reads, required %0d matching",
                 it, got_r.size(), exp_r.size());
      end
`ifdef LINE_WIN_AXIS_REPORT_EN
      checks++;
      if (ax != ((m_win != 0) ? m_axis : 0)) begin
        errors++;
        $display("FAIL rand_%0d axis: got %0d, required %0d", it, ax, m_axis);
      end
`endif
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.row = '0;
    bus.col = '0;
    bus.player = '0;
    clear_board();
    test_reset();
    test_vertical();
    test_invalid();
    test_horizontal();
    test_corner();
    test_broken();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_win_checker.md
# line_win_checker

Parametrised win detector for the connect-four datapath. After a move is committed, it scans the four line axes through the placed piece and reports whether the mover has a line of WIN_LEN. It reads the board memory through a one-cycle synchronous read port and never issues an out-of-board address. It replaces the fixed single-direction, fixed-length checker, which wrapped coordinates modulo 8.

## Interface
- ROWS, 6, board rows; row 0 is the bottom row.
- COLS, 7, board columns.
- RW, 3, row coordinate width; requires 2^RW >= ROWS.
- CW, 3, column coordinate width; requires 2^CW >= COLS.
- WIN_LEN, 4, required line length; range 2..min(ROWS,COLS).
- PW, 2, piece code width; code 0 means empty.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a check; sampled only in IDLE.
- row  in  RW  row of the placed piece.
- col  in  CW  column of the placed piece.
- player  in  PW  code of the mover.
- rd_en  out  1  board read strobe.
- rd_row  out  RW  board read row.
- rd_col  out  CW  board read column.
- rd_data  in  PW  board read data; valid the cycle after rd_en.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- winner  out  PW  player on a win, else 0; held until the next accepted start.
- win_axis  out  2  winning axis; exists only under the configuration macro.

## Operation
- Accepted start (IDLE & start) latches row, col and player, clears winner, and enters PROBE with axis 0, positive ray, dist 1, count 0.
- Invalid start: if player==0, row>=ROWS or col>=COLS, the block goes to DONE next cycle with winner 0 and issues no reads.
- Axis steps (dr,dc): 0=(+1,0) vertical; 1=(0,+1) horizontal; 2=(+1,+1) diagonal; 3=(+1,-1) anti-diagonal. The negative ray uses the negated step.
- Probe coordinate = anchor + sign*dist*step, computed at RW+1/CW+1 signed width. It is out of bounds if <0, >=ROWS or >=COLS. The anchor cell itself is never read; it is taken to equal player.
- PROBE state:
  - If dist==WIN_LEN or the probe is out of bounds, the ray ends with no read.
  - Otherwise rd_en=1 with the probe address, and the next state is CHECK.
- CHECK state:
  - rd_data==player: count+1 and dist+1. If count reaches WIN_LEN-1, winner<=player and go to DONE. Otherwise return to PROBE.
  - Any other value, including the opponent or empty: the ray ends.
- Ray end:
  - Positive ray: switch to the negative ray with dist=1 and count kept. The next state is PROBE.
  - Negative ray: move to the next axis with count=0, positive ray, dist=1. After axis 3 the next state is DONE with winner 0.
- DONE: done=1 for exactly one cycle, then IDLE. winner and win_axis hold.
- rd_en, rd_row and rd_col are decoded from registers only, with no input-to-output path.
- rd_row and rd_col read 0 whenever rd_en=0.

## Timing
- Reset values: busy 0, done 0, rd_en 0, rd_row 0, rd_col 0, winner 0, win_axis 0; state IDLE.
- Reset mid-scan aborts immediately to these values. No done is produced.
- Cycle cost:
  - Each read costs 2 cycles (PROBE plus CHECK).
  - A no-read ray end costs 1 PROBE cycle.
  - A CHECK mismatch moves straight to the next ray's PROBE at no extra cost.
- Latency is bounded by 16*WIN_LEN cycles from start to done.
- start while busy or in DONE is ignored.
- The next start is accepted in the cycle after done.

## Configuration
- LINE_WIN_AXIS_REPORT_EN defined:
  - The win_axis port exists.
  - It is loaded with the axis index on a win, cleared to 0 at accepted start and on reset, and held otherwise.
- LINE_WIN_AXIS_REPORT_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Vertical win. Defaults; player 1 at (0,2),(1,2),(2,2); start with (3,2), player=1.
  - Reads (4,2),(2,2),(1,2),(0,2).
  - done in cycle 9 after start; winner=1; win_axis=0.
- Horizontal win. Player 2 at (0,0),(0,1),(0,2); start with (0,3), player=2.
  - Reads (1,3),(0,4),(0,2),(0,1),(0,0).
  - done in cycle 12; winner=2; win_axis=1.
- Corner with empty board. Start with (5,6), player=1.
  - Reads only (4,6),(5,5),(4,5); no out-of-board address is ever driven.
  - done in cycle 12; winner=0.
- Broken line.
  - Player 1 at (0,0),(0,1),(0,4); start with (0,2): winner=0.
  - Repeat with player 2 at (0,3) and player 1 at (0,4): winner=0.
- Control.
  - start pulsed while busy: ignored.
  - rst_n low mid-scan: all outputs 0 the same cycle; no done pulse.
  - Start with player=0: done in cycle 1, no rd_en, winner=0.
